// File: rtl/data_path.sv
// Bus-organised 32-bit data path: R0-R15, PC, IR, MAR, MDR, Y, Zlo and an ALU, all joined by one multiplexed bus.
// The shift/rotate group is built only when DATAPATH_SHIFT_ROTATE_EN is defined; otherwise those strobes yield zero.

module data_path_reg32 (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk) begin
    if (clear)   q <= '0;
    else if (en) q <= d;
  end
endmodule

module data_path (
  input  logic        Clock,
  input  logic        clear,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        PCin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  input  logic        IncPC,
  input  logic        AND,
  input  logic        OR,
  input  logic        ADD,
  input  logic        SUB,
  input  logic        SHR,
  input  logic        SHRA,
  input  logic        SHL,
  input  logic        ROR,
  input  logic        ROL,
  input  logic        NEG,
  input  logic        NOT,
  output logic [31:0] ir_value,
  output logic [31:0] mar_value
);

  logic [31:0] BusMuxOut;
  logic [31:0] BusMuxInR0,  BusMuxInR1,  BusMuxInR2,  BusMuxInR3;
  logic [31:0] BusMuxInR4,  BusMuxInR5,  BusMuxInR6,  BusMuxInR7;
  logic [31:0] BusMuxInR8,  BusMuxInR9,  BusMuxInR10, BusMuxInR11;
  logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15;
  logic [31:0] BusMuxInPC;
  logic [31:0] BusMuxInMDR;
  logic [31:0] BusMuxInIR;
  logic [31:0] BusMuxInZlo;
  logic [31:0] Y_Out;
  logic [31:0] mar_q;
  logic [31:0] mdr_d;
  logic [31:0] alu_result;
  logic [4:0]  amt;

  // General-purpose register file
  data_path_reg32 reg_r0  (.clk(Clock), .clear(clear), .en(R0in),  .d(BusMuxOut), .q(BusMuxInR0));
  data_path_reg32 reg_r1  (.clk(Clock), .clear(clear), .en(R1in),  .d(BusMuxOut), .q(BusMuxInR1));
  data_path_reg32 reg_r2  (.clk(Clock), .clear(clear), .en(R2in),  .d(BusMuxOut), .q(BusMuxInR2));
  data_path_reg32 reg_r3  (.clk(Clock), .clear(clear), .en(R3in),  .d(BusMuxOut), .q(BusMuxInR3));
  data_path_reg32 reg_r4  (.clk(Clock), .clear(clear), .en(R4in),  .d(BusMuxOut), .q(BusMuxInR4));
  data_path_reg32 reg_r5  (.clk(Clock), .clear(clear), .en(R5in),  .d(BusMuxOut), .q(BusMuxInR5));
  data_path_reg32 reg_r6  (.clk(Clock), .clear(clear), .en(R6in),  .d(BusMuxOut), .q(BusMuxInR6));
  data_path_reg32 reg_r7  (.clk(Clock), .clear(clear), .en(R7in),  .d(BusMuxOut), .q(BusMuxInR7));
  data_path_reg32 reg_r8  (.clk(Clock), .clear(clear), .en(R8in),  .d(BusMuxOut), .q(BusMuxInR8));
  data_path_reg32 reg_r9  (.clk(Clock), .clear(clear), .en(R9in),  .d(BusMuxOut), .q(BusMuxInR9));
  data_path_reg32 reg_r10 (.clk(Clock), .clear(clear), .en(R10in), .d(BusMuxOut), .q(BusMuxInR10));
  data_path_reg32 reg_r11 (.clk(Clock), .clear(clear), .en(R11in), .d(BusMuxOut), .q(BusMuxInR11));
  data_path_reg32 reg_r12 (.clk(Clock), .clear(clear), .en(R12in), .d(BusMuxOut), .q(BusMuxInR12));
  data_path_reg32 reg_r13 (.clk(Clock), .clear(clear), .en(R13in), .d(BusMuxOut), .q(BusMuxInR13));
  data_path_reg32 reg_r14 (.clk(Clock), .clear(clear), .en(R14in), .d(BusMuxOut), .q(BusMuxInR14));
  data_path_reg32 reg_r15 (.clk(Clock), .clear(clear), .en(R15in), .d(BusMuxOut), .q(BusMuxInR15));

  // Special-purpose registers; MDR alone can take data from outside the bus
  assign mdr_d = Read ? Mdatain : BusMuxOut;

  data_path_reg32 reg_pc  (.clk(Clock), .clear(clear), .en(PCin),  .d(BusMuxOut),  .q(BusMuxInPC));
  data_path_reg32 reg_ir  (.clk(Clock), .clear(clear), .en(IRin),  .d(BusMuxOut),  .q(BusMuxInIR));
  data_path_reg32 MAR     (.clk(Clock), .clear(clear), .en(MARin), .d(BusMuxOut),  .q(mar_q));
  data_path_reg32 reg_mdr (.clk(Clock), .clear(clear), .en(MDRin), .d(mdr_d),      .q(BusMuxInMDR));
  data_path_reg32 reg_y   (.clk(Clock), .clear(clear), .en(Yin),   .d(BusMuxOut),  .q(Y_Out));
  data_path_reg32 reg_zlo (.clk(Clock), .clear(clear), .en(Zin),   .d(alu_result), .q(BusMuxInZlo));

  assign ir_value  = BusMuxInIR;
  assign mar_value = mar_q;

  // Bus source mux: the first asserted select in this chain wins
  always_comb begin
    BusMuxOut = '0;
    if (MDRout)       BusMuxOut = BusMuxInMDR;
    else if (Zlowout) BusMuxOut = BusMuxInZlo;
    else if (PCout)   BusMuxOut = BusMuxInPC;
    else if (R0out)   BusMuxOut = BusMuxInR0;
    else if (R1out)   BusMuxOut = BusMuxInR1;
    else if (R2out)   BusMuxOut = BusMuxInR2;
    else if (R3out)   BusMuxOut = BusMuxInR3;
    else if (R4out)   BusMuxOut = BusMuxInR4;
    else if (R5out)   BusMuxOut = BusMuxInR5;
    else if (R6out)   BusMuxOut = BusMuxInR6;
    else if (R7out)   BusMuxOut = BusMuxInR7;
    else if (R8out)   BusMuxOut = BusMuxInR8;
    else if (R9out)   BusMuxOut = BusMuxInR9;
    else if (R10out)  BusMuxOut = BusMuxInR10;
    else if (R11out)  BusMuxOut = BusMuxInR11;
    else if (R12out)  BusMuxOut = BusMuxInR12;
    else if (R13out)  BusMuxOut = BusMuxInR13;
    else if (R14out)  BusMuxOut = BusMuxInR14;
    else if (R15out)  BusMuxOut = BusMuxInR15;
  end

  assign amt = BusMuxOut[4:0];

  // ALU: A is the Y latch, B is the live bus; strobes are prioritised in declaration order.
  // Rotates combine two shifts; a left shift by 32 yields zero so amount 0 returns A.
  always_comb begin
    alu_result = '0;
    if (IncPC)     alu_result = BusMuxOut + 32'd1;
    else if (AND)  alu_result = Y_Out & BusMuxOut;
    else if (OR)   alu_result = Y_Out | BusMuxOut;
    else if (ADD)  alu_result = Y_Out + BusMuxOut;
    else if (SUB)  alu_result = Y_Out - BusMuxOut;
`ifdef DATAPATH_SHIFT_ROTATE_EN
    else if (SHR)  alu_result = Y_Out >> amt;
    else if (SHRA) alu_result = $signed(Y_Out) >>> amt;
    else if (SHL)  alu_result = Y_Out << amt;
    else if (ROR)  alu_result = (Y_Out >> amt) | (Y_Out << (6'd32 - {1'b0, amt}));
    else if (ROL)  alu_result = (Y_Out << amt) | (Y_Out >> (6'd32 - {1'b0, amt}));
`else
    else if (SHR | SHRA | SHL | ROR | ROL) alu_result = '0;
`endif
    else if (NEG)  alu_result = 32'd0 - BusMuxOut;
    else if (NOT)  alu_result = ~BusMuxOut;
  end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed bus/ALU/fetch/reset steps, then randomized micro-operations
// checked against an array-based model. Mirrors DATAPATH_SHIFT_ROTATE_EN when computing expectations.

module tb_data_path;

`ifdef DATAPATH_SHIFT_ROTATE_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  // op bit order: 0 IncPC,1 AND,2 OR,3 ADD,4 SUB,5 SHR,6 SHRA,7 SHL,8 ROR,9 ROL,10 NEG,11 NOT
  localparam int OP_INC = 0, OP_AND = 1, OP_OR = 2, OP_ADD = 3, OP_SUB = 4, OP_SHR = 5;
  localparam int OP_SHRA = 6, OP_SHL = 7, OP_ROR = 8, OP_ROL = 9, OP_NEG = 10, OP_NOT = 11;

  logic        Clock = 1'b0;
  logic        clear;
  logic [15:0] r_out, r_in;
  logic        pc_out, zlo_out, mdr_out;
  logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, rd;
  logic [31:0] mdatain;
  logic [11:0] op;
  logic [31:0] ir_value, mar_value;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_z;
  logic [31:0] exp_q [$];

  data_path dut (
    .Clock(Clock), .clear(clear),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .PCout(pc_out), .Zlowout(zlo_out), .MDRout(mdr_out),
    .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
    .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
    .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .PCin(pc_in), .MARin(mar_in), .MDRin(mdr_in), .IRin(ir_in), .Yin(y_in), .Zin(z_in),
    .Read(rd), .Mdatain(mdatain),
    .IncPC(op[OP_INC]), .AND(op[OP_AND]), .OR(op[OP_OR]), .ADD(op[OP_ADD]), .SUB(op[OP_SUB]),
    .SHR(op[OP_SHR]), .SHRA(op[OP_SHRA]), .SHL(op[OP_SHL]), .ROR(op[OP_ROR]), .ROL(op[OP_ROL]),
    .NEG(op[OP_NEG]), .NOT(op[OP_NOT]),
    .ir_value(ir_value), .mar_value(mar_value)
  );

  // Clock and watchdog
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model
  function automatic logic [31:0] alu_model(input logic [11:0] ops, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [63:0] dbl;
    logic [63:0] t;
    int k;
    sh  = int'(b[4:0]);
    dbl = {a, a};
    k = -1;
    for (int i = 11; i >= 0; i--) if (ops[i]) k = i;
    if (!SH_EN && k >= OP_SHR && k <= OP_ROL) return 32'h0;
    case (k)
      OP_INC:  return b + 32'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHR:  return a >> sh;
      OP_SHRA: return a[31] ? ~((~a) >> sh) : (a >> sh);
      OP_SHL:  return a << sh;
      OP_ROR:  begin t = dbl >> sh; return t[31:0]; end
      OP_ROL:  begin t = dbl << sh; return t[63:32]; end
      OP_NEG:  return 32'd0 - b;
      OP_NOT:  return ~b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] bus_model();
    if (mdr_out) return m_mdr;
    if (zlo_out) return m_z;
    if (pc_out)  return m_pc;
    for (int i = 0; i < 16; i++) if (r_out[i]) return m_r[i];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_reg(input int i);
    if (i < 16) return m_r[i];
    case (i)
      16: return m_pc;
      17: return m_ir;
      18: return m_mar;
      19: return m_mdr;
      20: return m_y;
      default: return m_z;
    endcase
  endfunction

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return dut.BusMuxInR0;   1: return dut.BusMuxInR1;   2: return dut.BusMuxInR2;
      3: return dut.BusMuxInR3;   4: return dut.BusMuxInR4;   5: return dut.BusMuxInR5;
      6: return dut.BusMuxInR6;   7: return dut.BusMuxInR7;   8: return dut.BusMuxInR8;
      9: return dut.BusMuxInR9;   10: return dut.BusMuxInR10; 11: return dut.BusMuxInR11;
      12: return dut.BusMuxInR12; 13: return dut.BusMuxInR13; 14: return dut.BusMuxInR14;
      15: return dut.BusMuxInR15; 16: return dut.BusMuxInPC;  17: return dut.BusMuxInIR;
      18: return dut.MAR.q;       19: return dut.BusMuxInMDR; 20: return dut.Y_Out;
      default: return dut.BusMuxInZlo;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 22; i++) check($sformatf("%s_reg%0d", tag, i), dut_reg(i), model_reg(i));
  endtask

  // Drivers
  task automatic idle();
    clear = 1'b0; r_out = '0; r_in = '0;
    pc_out = 1'b0; zlo_out = 1'b0; mdr_out = 1'b0;
    pc_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
    rd = 1'b0; op = '0;
  endtask

  // One clock with the currently driven controls; the model advances alongside the DUT.
  task automatic tick();
    logic [31:0] bus, alu;
    @(negedge Clock);
    bus = bus_model();
    alu = alu_model(op, m_y, bus);
    check("bus", dut.BusMuxOut, bus);
    if (!clear && z_in) exp_q.push_back(alu);
    @(posedge Clock);
    #1;
    if (clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = '0;
      m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;
    end else begin
      for (int i = 0; i < 16; i++) if (r_in[i]) m_r[i] = bus;
      if (pc_in)  m_pc  = bus;
      if (mar_in) m_mar = bus;
      if (ir_in)  m_ir  = bus;
      if (y_in)   m_y   = bus;
      if (mdr_in) m_mdr = rd ? mdatain : bus;
      if (z_in) begin
        m_z = alu;
        if (exp_q.size() > 0) check("zlo_sb", dut.BusMuxInZlo, exp_q.pop_front());
      end
    end
  endtask

  task automatic load_reg(input int dst, input logic [31:0] v);
    idle(); mdatain = v; rd = 1'b1; mdr_in = 1'b1; tick();
    idle(); mdr_out = 1'b1; r_in[dst] = 1'b1; tick();
  endtask

  task automatic load_y(input int src);
    idle(); r_out[src] = 1'b1; y_in = 1'b1; tick();
  endtask

  task automatic alu_op(input int src, input int opbit, input string tag, input logic [31:0] expv);
    idle(); r_out[src] = 1'b1; z_in = 1'b1; op[opbit] = 1'b1; tick();
    check(tag, dut.BusMuxInZlo, expv);
  endtask

  function automatic logic [31:0] sh_exp(input logic [31:0] v);
    return SH_EN ? v : 32'h0;
  endfunction

  initial begin
    idle();
    mdatain = '0;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;

    // Reset state
    clear = 1'b1; tick();
    check_all("reset");

    // Register loads through MDR
    load_reg(3, 32'h22);
    check("load_r3", dut.BusMuxInR3, 32'h22);
    load_reg(7, 32'h24);
    check("load_r7", dut.BusMuxInR7, 32'h24);

    // Instruction fetch from PC=0
    idle(); pc_out = 1'b1; mar_in = 1'b1; op[OP_INC] = 1'b1; z_in = 1'b1; tick();
    idle(); zlo_out = 1'b1; pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1; mdatain = 32'h2A2B8000; tick();
    idle(); mdr_out = 1'b1; ir_in = 1'b1; tick();
    check("fetch_mar", dut.MAR.q, 32'h0);
    check("fetch_pc", dut.BusMuxInPC, 32'h1);
    check("fetch_ir", dut.BusMuxInIR, 32'h2A2B8000);
    check("fetch_ir_port", ir_value, 32'h2A2B8000);
    check("fetch_mar_port", mar_value, 32'h0);

    // Two-operand ALU, Y=0x22 and B=0x24
    load_y(3);
    alu_op(7, OP_AND, "and", 32'h20);
    alu_op(7, OP_OR,  "or",  32'h26);
    alu_op(7, OP_ADD, "add", 32'h46);
    alu_op(7, OP_SUB, "sub", 32'hFFFFFFFE);
    alu_op(7, OP_SHR, "shr", sh_exp(32'h2));
    alu_op(7, OP_SHL, "shl", sh_exp(32'h220));
    alu_op(7, OP_ROR, "ror", sh_exp(32'h20000002));
    alu_op(7, OP_ROL, "rol", sh_exp(32'h220));
    load_reg(1, 32'h80000000);
    load_y(1);
    alu_op(7, OP_SHRA, "shra", sh_exp(32'hF8000000));

    // Shift amount zero returns A unchanged
    load_reg(4, 32'h40);
    alu_op(4, OP_ROR, "ror_zero", sh_exp(32'h80000000));
    alu_op(4, OP_SHRA, "shra_zero", sh_exp(32'h80000000));

    // Unary ops and Zlo onto bus
    load_reg(2, 32'h28);
    alu_op(2, OP_NEG, "neg", 32'hFFFFFFD8);
    alu_op(2, OP_NOT, "not", 32'hFFFFFFD7);
    idle(); zlo_out = 1'b1; r_in[5] = 1'b1; tick();
    check("zlo_to_r5", dut.BusMuxInR5, 32'hFFFFFFD7);

    // No select -> zero bus; MDR wins over Zlo
    idle();
    @(negedge Clock);
    check("bus_idle", dut.BusMuxOut, 32'h0);
    mdr_out = 1'b1; zlo_out = 1'b1;
    #1;
    check("bus_mdr_over_zlo", dut.BusMuxOut, 32'h28);

    // Same register as source and destination keeps its value
    idle(); r_out[3] = 1'b1; r_in[3] = 1'b1; tick();
    check("self_load_r3", dut.BusMuxInR3, 32'h22);
    check_all("directed");

    // Randomized micro-operations
    for (int n = 0; n < 400; n++) begin
      idle();
      r_out   = 16'($urandom_range(0, 3) == 0 ? $urandom : (32'h1 << $urandom_range(0, 16)));
      pc_out  = ($urandom_range(0, 7) == 0);
      zlo_out = ($urandom_range(0, 5) == 0);
      mdr_out = ($urandom_range(0, 5) == 0);
      r_in    = 16'($urandom_range(0, 3) == 0 ? (32'h1 << $urandom_range(0, 15)) : 32'h0);
      pc_in   = ($urandom_range(0, 7) == 0);
      mar_in  = ($urandom_range(0, 5) == 0);
      mdr_in  = ($urandom_range(0, 2) == 0);
      ir_in   = ($urandom_range(0, 5) == 0);
      y_in    = ($urandom_range(0, 2) == 0);
      z_in    = ($urandom_range(0, 1) == 0);
      rd      = $urandom_range(0, 1) == 1;
      mdatain = $urandom;
      op      = 12'(32'h1 << $urandom_range(0, 12));
      if ($urandom_range(0, 4) == 0) op = op | 12'($urandom);
      clear   = ($urandom_range(0, 60) == 0);
      tick();
    end
    check_all("random");

    // Reset aborts a fetch in progress
    idle(); load_reg(6, 32'hCAFE0001);
    idle(); pc_out = 1'b1; mar_in = 1'b1; op[OP_INC] = 1'b1; z_in = 1'b1; tick();
    idle(); zlo_out = 1'b1; pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1; r_in = 16'hFFFF;
    mdatain = 32'h12345678; clear = 1'b1; tick();
    check_all("abort");
    check("abort_pc", dut.BusMuxInPC, 32'h0);
    idle(); mdr_out = 1'b1; zlo_out = 1'b1; pc_out = 1'b1; r_out = 16'hFFFF;
    @(negedge Clock);
    check("bus_after_clear", dut.BusMuxOut, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 The module SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 Clock  in  1  sole clock; all storage updates on its rising edge.
REQ-003 clear  in  1  synchronous active-high reset.
REQ-004 R0out..R15out, PCout, Zlowout, MDRout  in  1 each  bus-source selects.
REQ-005 R0in..R15in, PCin, MARin, MDRin, IRin, Yin, Zin  in  1 each  register load enables.
REQ-006 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-007 Mdatain  in  32  memory read data.
REQ-008 IncPC, AND, OR, ADD, SUB, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  in  1 each  ALU operation strobes.
REQ-009 Internal nets SHALL be named BusMuxOut, BusMuxInR0..BusMuxInR15, BusMuxInPC, BusMuxInMDR, BusMuxInIR, BusMuxInZlo and Y_Out; the MAR instance SHALL be MAR with output q. Benches probe these hierarchically.

Function
REQ-010 Storage: R0-R15, PC, IR, MAR, MDR, Y and Z (Zlo), each 32 bits; each loads on the rising edge when its enable is 1 and holds otherwise.
REQ-011 BusMuxOut is combinational. Fixed priority when several selects are high: MDRout > Zlowout > PCout > R0out > ... > R15out. With no select high, the bus is 32'h0.
REQ-012 MDR loads Mdatain when Read=1 and BusMuxOut when Read=0, in both cases only while MDRin=1.
REQ-013 Every other register loads from BusMuxOut.
REQ-014 ALU operands: A = Y_Out and B = BusMuxOut. The result is combinational and is captured into Zlo when Zin=1.
REQ-015 Operations, with strobe priority in the listed order:
- IncPC: B+1
- AND: A&B
- OR: A|B
- ADD: A+B (mod 2^32)
- SUB: A-B (mod 2^32)
- SHR: A>>B[4:0], logical
- SHRA: A>>>B[4:0], arithmetic
- SHL: A<<B[4:0]
- ROR: A rotated right by B[4:0]
- ROL: A rotated left by B[4:0]
- NEG: -B (two's complement)
- NOT: ~B
- no strobe: 32'h0
REQ-016 Shift or rotate amount 0 SHALL return A unchanged. Carry and overflow are discarded.
REQ-017 Instruction fetch over the bus:
- T0: PCout, MARin, IncPC, Zin
- T1: Zlowout, PCin, Read, MDRin
- T2: MDRout, IRin
REQ-018 A register selected as both source and destination in the same cycle SHALL load its own old value, with no combinational loop.
REQ-019 BusMuxInZlo, BusMuxInIR and Y_Out SHALL reflect their register contents with no added latency.

Reset
REQ-020 With clear=1 at a rising edge, all registers SHALL become 32'h0 (R0-R15, PC, IR, MAR, MDR, Y, Zlo); clear overrides every load enable.
REQ-021 After clear, BusMuxOut SHALL be 32'h0 regardless of which selects are high.
REQ-022 Reset during a multi-cycle sequence SHALL abort it; no partial state survives.

Configuration
REQ-023 Macro DATAPATH_SHIFT_ROTATE_EN:
- Defined: SHR, SHRA, SHL, ROR and ROL SHALL be implemented per REQ-015.
- Undefined: those strobes SHALL produce 32'h0; all other operations are unchanged.

Verification
REQ-024 Load: Mdatain=0x22, Read=1, MDRin=1, then MDRout, R3in -> R3=0x22. Load R7=0x24 the same way.
REQ-025 Fetch from PC=0 with Mdatain=0x2A2B8000 -> MAR=0, PC=1, IR=0x2A2B8000 after T2.
REQ-026 With Y=R3=0x22 and R7out, Zin, check each result:
- AND -> Zlo=0x20
- OR -> 0x26
- ADD -> 0x46
- SUB -> 0xFFFFFFFE
REQ-027 With Y=0x22 and B=0x24 (amount 4), check each result:
- SHR -> 0x2
- SHL -> 0x220
- ROR -> 0x20000002
- ROL -> 0x220
- SHRA with Y=0x80000000 -> 0xF8000000
REQ-028 Unary and bus default:
- NEG with B=0x28 -> 0xFFFFFFD8
- NOT with B=0x28 -> 0xFFFFFFD7
- no bus select -> BusMuxOut=0
- Zlowout, R5in -> R5=Zlo
REQ-029 Reset: clear=1 asserted mid-sequence -> all registers 0 on the next edge; MDRout and Zlowout together -> bus carries MDR.
